// File: rtl/alarm_control_fsm.sv
// Car-alarm sequencing controller: arm/trigger/siren timing from ignition, door and 1 Hz tick inputs.
// Status code, siren and seconds-remaining are registered alongside the state, so no input reaches an output combinationally.
module alarm_control_fsm #(
  parameter int unsigned T_ARM_DELAY       = 6,
  parameter int unsigned T_DRIVER_DELAY    = 8,
  parameter int unsigned T_PASSENGER_DELAY = 15,
  parameter int unsigned T_ALARM_ON        = 10
) (
  input  logic       clock_25mhz,
  input  logic       reset_n,
  input  logic       one_hz_enable,
  input  logic       ignition,
  input  logic       driver_door,
  input  logic       passenger_door,
  output logic [1:0] status_indicator_led_status,
  output logic       siren,
  output logic [3:0] time_remaining
);

  // state             | meaning
  // S_ARMED           | armed, LED blinking, watching both doors
  // S_TRIGGERED       | door opened while armed, grace countdown running
  // S_SOUNDING        | siren on, waiting for every door to close
  // S_SOUND_HOLD      | siren on, hold countdown after doors closed
  // S_DISARMED        | ignition on (or just dropped)
  // S_WAIT_DOOR_OPEN  | ignition off, waiting for driver to get out
  // S_WAIT_DOOR_CLOSE | driver door open, waiting for it to close
  // S_ARM_DELAY       | driver door closed, arm countdown running
  typedef enum logic [2:0] {
    S_ARMED           = 3'd0,
    S_TRIGGERED       = 3'd1,
    S_SOUNDING        = 3'd2,
    S_SOUND_HOLD      = 3'd3,
    S_DISARMED        = 3'd4,
    S_WAIT_DOOR_OPEN  = 3'd5,
    S_WAIT_DOOR_CLOSE = 3'd6,
    S_ARM_DELAY       = 3'd7
  } state_t;

  localparam logic [1:0] LED_OFF   = 2'b00;
  localparam logic [1:0] LED_SOLID = 2'b01;
  localparam logic [1:0] LED_BLINK = 2'b11;

  localparam logic [3:0] LOAD_ARM       = 4'(T_ARM_DELAY);
  localparam logic [3:0] LOAD_DRIVER    = 4'(T_DRIVER_DELAY);
  localparam logic [3:0] LOAD_PASSENGER = 4'(T_PASSENGER_DELAY);
  localparam logic [3:0] LOAD_ALARM_ON  = 4'(T_ALARM_ON);

  state_t     state;
  state_t     state_next;
  logic [3:0] count;
  logic [3:0] count_next;
  logic [3:0] count_dec;
  logic       expire;
  logic       any_door;

  function automatic logic [1:0] led_code(input state_t s);
    case (s)
      S_ARMED:                                return LED_BLINK;
      S_TRIGGERED, S_SOUNDING, S_SOUND_HOLD:  return LED_SOLID;
      default:                                return LED_OFF;
    endcase
  endfunction

  function automatic logic siren_code(input state_t s);
    return (s == S_SOUNDING) || (s == S_SOUND_HOLD);
  endfunction

  // Terminal count is 1 so the state leaves on the same tick that drains the counter to 0.
  assign expire    = one_hz_enable && (count == 4'd1);
  assign count_dec = (one_hz_enable && (count != 4'd0)) ? count - 4'd1 : count;
  assign any_door  = driver_door || passenger_door;

  always_comb begin
    state_next = state;
    count_next = 4'd0;
    if (ignition) begin
      state_next = S_DISARMED;
    end else begin
      case (state)
        S_ARMED: begin
          if (driver_door) begin
            state_next = S_TRIGGERED;
            count_next = LOAD_DRIVER;
          end else if (passenger_door) begin
            state_next = S_TRIGGERED;
            count_next = LOAD_PASSENGER;
          end
        end
        S_TRIGGERED: begin
          if (expire) state_next = S_SOUNDING;
          else        count_next = count_dec;
        end
        S_SOUNDING: begin
          if (!any_door) begin
            state_next = S_SOUND_HOLD;
            count_next = LOAD_ALARM_ON;
          end
        end
        S_SOUND_HOLD: begin
          if (any_door)    state_next = S_SOUNDING;
          else if (expire) state_next = S_ARMED;
          else             count_next = count_dec;
        end
        S_DISARMED: begin
          state_next = S_WAIT_DOOR_OPEN;
        end
        S_WAIT_DOOR_OPEN: begin
          if (driver_door) state_next = S_WAIT_DOOR_CLOSE;
        end
        S_WAIT_DOOR_CLOSE: begin
          if (!driver_door) begin
            state_next = S_ARM_DELAY;
            count_next = LOAD_ARM;
          end
        end
        S_ARM_DELAY: begin
          if (driver_door) state_next = S_WAIT_DOOR_CLOSE;
          else if (expire) state_next = S_ARMED;
          else             count_next = count_dec;
        end
        default: begin
          state_next = S_ARMED;
        end
      endcase
    end
  end

  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state                       <= S_ARMED;
      count                       <= 4'd0;
      status_indicator_led_status <= LED_BLINK;
      siren                       <= 1'b0;
      time_remaining              <= 4'd0;
    end else begin
      state                       <= state_next;
      count                       <= count_next;
      status_indicator_led_status <= led_code(state_next);
      siren                       <= siren_code(state_next);
      time_remaining              <= count_next;
    end
  end

endmodule
